event_blinker: RTL
==================

# event_blinker

Output-side companion to the button debouncer. It turns single-cycle event pulses, such as a debounced press, into human-visible LED blinks of fixed on/off duration. Events that arrive while a blink is in progress are queued in a saturating counter, so every press is shown as one distinct blink. It sits between the debounced event sources and the board LEDs.

## Interface
- `ON_CYCLES`, default 2000000: LED-on duration in clock cycles; must be ≥1.
- `OFF_CYCLES`, default 2000000: mandatory dark gap after each blink, in clock cycles; must be ≥1.
- `MAX_PENDING`, default 7: queue depth for pending events; must be ≥1.

- `clk_i`, input, 1: the single clock.
- `rst_ni`, input, 1: reset. Synchronous and active-low.
- `pulse_i`, input, 1: event strobe. Each cycle it is high counts as one event.
- `led_o`, output, 1: blink output.
- `busy_o`, output, 1: high whenever the block is not in IDLE.
- `pending_o`, output, `$clog2(MAX_PENDING+1)`: number of queued events not yet shown.
- `overflow_o`, output, 1: sticky flag. Set when an event is dropped; cleared only by reset.

## Operation
- States are IDLE, ON and OFF.
- Cycle counter:
  - width is `$clog2(max(ON_CYCLES,OFF_CYCLES))`, minimum 1;
  - it is cleared on every state entry.
- Reset (`rst_ni`=0 at a clock edge):
  - the state returns to IDLE;
  - the counter, `pending_o`, `overflow_o`, `led_o` and `busy_o` all go to 0;
  - `pulse_i` is ignored during reset;
  - reset applied mid-blink discards the queue.
- IDLE:
  - `pulse_i`=1 moves to ON;
  - pending is unchanged (it stays 0).
- ON:
  - the counter increments each cycle;
  - at count `ON_CYCLES-1` the block moves to OFF.
- OFF:
  - the counter increments each cycle;
  - at count `OFF_CYCLES-1`, if the effective pending count is >0 (see below), the block moves to ON and pending decrements;
  - otherwise it moves to IDLE.
- Queueing, for `pulse_i`=1 in ON or OFF:
  - pending increments by 1, saturating at `MAX_PENDING`;
  - a pulse arriving at saturation is dropped and sets `overflow_o`.
- Simultaneous events on the last OFF cycle:
  - The pulse and the dequeue are both counted. The pending count is unchanged and the block moves to ON.
  - This holds even when pending=0: the new pulse is dequeued directly and pending stays 0.
  - At saturation this case does not set `overflow_o`, because the net count is unchanged.
- Outputs:
  - `led_o` = (state==ON);
  - `busy_o` = (state!=IDLE);
  - all outputs come straight from registers, with no combinational path from `pulse_i`.

## Timing
- Pulse in IDLE at cycle 0:
  - `led_o` is high for cycles 1..`ON_CYCLES`;
  - `led_o` is low for cycles `ON_CYCLES+1`..`ON_CYCLES+OFF_CYCLES`;
  - `busy_o` falls at cycle `ON_CYCLES+OFF_CYCLES+1` if nothing is queued.
- Back-to-back blinks:
  - `led_o` is low for exactly `OFF_CYCLES` between blinks;
  - there is no IDLE cycle between them.
- Latency from pulse to LED is 1 cycle.
- `pending_o` updates in the cycle after the pulse.
- `overflow_o` sets in the cycle after the dropped pulse.

## Structure
- Shared package `blink_pkg`:
  - the state enum typedef `blink_state_t` (IDLE, ON, OFF), 2 bits;
  - a `$clog2`-based width helper for the pending counter.
- One natural sub-module, `blink_timer`:
  - a clear-able up-counter with a terminal-count input;
  - a registered-free `done` output that is high when count == terminal-1;
  - it is instantiated once and shared by ON and OFF.
- The FSM and the pending counter stay in `event_blinker`.

## Test plan
All scenarios use `ON_CYCLES`=4, `OFF_CYCLES`=3, `MAX_PENDING`=2.
- Single pulse in IDLE at cycle 0:
  - `led_o`=1 for cycles 1–4 and 0 for cycles 5–7;
  - `busy_o`=0 from cycle 8;
  - `pending_o`=0 throughout.
- Four 1-cycle pulses at cycles 0, 1, 2, 3:
  - `pending_o` reads 1, then 2, then stays at 2;
  - `overflow_o`=1 from cycle 4;
  - exactly 3 blinks, separated by 3-cycle gaps.
- Pulse on the last OFF cycle (cycle 7) with `pending_o`=0:
  - `led_o`=1 at cycle 8;
  - `busy_o` never drops;
  - `pending_o` stays 0.
- Reset pulsed low at cycle 2 of a blink with `pending_o`=2 and `pulse_i`=1:
  - at the next cycle, `led_o`, `busy_o`, `pending_o` and `overflow_o` are all 0;
  - no further blink occurs.
- `pulse_i` held high for cycles 0–2 from IDLE:
  - this counts as 3 events;
  - 3 blinks result, with `overflow_o`=0.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and width helpers for the event blinker.
// Latency: n/a (types only).
// Backpressure: n/a.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } blink_state_t;

    function automatic int pending_width(input int max_pending);
        return $clog2(max_pending + 1);
    endfunction

    // Counter must hold values up to max(on, off) - 1; never narrower than 1 bit.
    function automatic int count_width(input int on_cycles, input int off_cycles);
        int m;
        m = (on_cycles > off_cycles) ? on_cycles : off_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Clear-able up-counter shared by the ON and OFF phases; done flags the last count.
// Latency: done is combinational from the count register.
// Backpressure: none, counts every cycle unless cleared.
module blink_timer
    import blink_pkg::*;
#(
    parameter int CW = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr,
    input  logic [CW:0]   terminal,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // terminal is one bit wider so the full ON/OFF length fits.
    assign done = ({1'b0, count} == (terminal - 1'b1));

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle events into fixed-length LED blinks, queueing overlapping events.
// Latency: pulse to led_o is 1 cycle; all outputs are registered.
// Backpressure: none; events beyond MAX_PENDING are dropped and flagged on overflow_o.
module event_blinker
    import blink_pkg::*;
#(
    parameter int ON_CYCLES   = 2000000,
    parameter int OFF_CYCLES  = 2000000,
    parameter int MAX_PENDING = 7
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 pulse_i,
    output logic                                 led_o,
    output logic                                 busy_o,
    output logic [$clog2(MAX_PENDING+1)-1:0]     pending_o,
    output logic                                 overflow_o
);

    localparam int CW = count_width(ON_CYCLES, OFF_CYCLES);
    localparam int PW = pending_width(MAX_PENDING);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    blink_state_t state;
    logic [CW:0]  terminal;
    logic         tmr_clr;
    logic         tmr_done;

    assign terminal = (state == ON) ? (CW+1)'(ON_CYCLES) : (CW+1)'(OFF_CYCLES);
    // Every state change happens on done (or out of IDLE), so this clears on each entry.
    assign tmr_clr  = (state == IDLE) || tmr_done;

    blink_timer #(
        .CW (CW)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      (tmr_clr),
        .terminal (terminal),
        .done     (tmr_done)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            led_o      <= 1'b0;
            busy_o     <= 1'b0;
            pending_o  <= '0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_i) begin
                        state  <= ON;
                        led_o  <= 1'b1;
                        busy_o <= 1'b1;
                    end
                end
                ON: begin
                    if (pulse_i) begin
                        if (pending_o == PEND_MAX) begin
                            overflow_o <= 1'b1;
                        end else begin
                            pending_o <= pending_o + 1'b1;
                        end
                    end
                    if (tmr_done) begin
                        state <= OFF;
                        led_o <= 1'b0;
                    end
                end
                OFF: begin
                    if (tmr_done) begin
                        // A pulse on the final gap cycle is consumed directly by the next blink.
                        if (pulse_i || (pending_o != '0)) begin
                            state <= ON;
                            led_o <= 1'b1;
                            if (!pulse_i) begin
                                pending_o <= pending_o - 1'b1;
                            end
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end else if (pulse_i) begin
                        if (pending_o == PEND_MAX) begin
                            overflow_o <= 1'b1;
                        end else begin
                            pending_o <= pending_o + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    led_o  <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
